pipe_hazard_unit: RTL
=====================

# pipe_hazard_unit

Parametrised hazard-detection, forwarding and pipeline-control block for the 5-stage in-order core (IF, ID, EX, MEM, WB). It tracks the destinations of the instructions in EX and MEM in an internal scoreboard and uses them to drive the pipeline:
- stage-register enables and flushes, for load-use stalls, branch/return redirects and external freezes;
- registered operand-forwarding selects for the EX-stage operand muxes.

It sits beside the top-level pipeline registers and replaces the tied-off `load_use` input and the unconnected forwarding selects.

## Interface
Parameters:
- AW, 3, register-address width.
- NUM_SRC, 2, source operands per instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src_addr  in  NUM_SRC*AW  source register addresses (source i at [i*AW +: AW]).
- id_src_used  in  NUM_SRC  source i is read.
- id_dst_addr  in  AW  destination register.
- id_reg_wr  in  1  instruction writes the register file.
- id_mem_rd  in  1  instruction is a load (result available only after MEM).
- ex_redirect  in  1  taken branch/jump/call resolved in EX.
- mem_redirect  in  1  RET/RTI PC pop resolved in MEM.
- ext_stall  in  1  freeze the whole pipeline (memory busy).
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID at the next edge.
- idex_bubble  out  1  load a NOP into ID/EX at the next edge.
- exmem_flush  out  1  clear EX/MEM at the next edge.
- fwd_sel  out  NUM_SRC*2  per-source EX operand select, registered.
- hazard_stall  out  1  a load-use or RAW stall is active this cycle.

## Operation
- Scoreboard: two entries (EX, MEM), each holding valid, dst, reg_wr and mem_rd. Both entries update only when ext_stall=0:
  - EX entry <= the ID fields when ID advances (id_valid, no bubble, no flush); otherwise EX.valid <= 0.
  - MEM entry <= the EX entry, or invalid if exmem_flush is asserted.
- Match rule: source i hits a stage when id_src_used[i], stage.valid, stage.reg_wr and stage.dst == id_src_addr[i]. R0 is not special.
- Load-use: a hit on an EX entry with mem_rd=1 forces the stall response for one cycle:
  - pc_en=0, ifid_en=0, idex_bubble=1, hazard_stall=1.
  - On the next cycle the load is in MEM and the consumer retries.
- fwd_sel encoding for source i (the value enters EX with the instruction):
  - 1 (FWD_EXMEM) for an EX hit;
  - else 2 (FWD_MEMWB) for a MEM hit;
  - else 0 (FWD_RF).
  - The youngest producer wins. The value 3 is never driven.
- The register file is write-through. A producer that is in WB while the consumer is in ID needs no action.
- Redirect priority: mem_redirect > ex_redirect > hazard stall.
  - mem_redirect: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_en=1, ifid_en=1, hazard_stall=0.
  - ex_redirect: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1, hazard_stall=0.
  - Any pending stall is dropped, because its consumer is on the wrong path.
- ext_stall=1 overrides everything else:
  - pc_en=0, ifid_en=0, all flush/bubble outputs 0;
  - scoreboard and fwd_sel hold;
  - redirect inputs are ignored, and the source must hold them until ext_stall falls.
- Idle defaults: pc_en=1, ifid_en=1, flushes/bubble 0.

## Timing
- pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush and hazard_stall are combinational from the ID inputs, the redirect inputs and the scoreboard, for use at the next edge.
- fwd_sel is registered. It is captured when the consumer moves ID->EX and is valid for the whole EX cycle. A bubble loads 0.
- Load-use costs exactly 1 cycle (2 cycles without forwarding, see Configuration).
- ex_redirect costs 2 cycles; mem_redirect costs 3 cycles.
- Reset values: scoreboard invalid, fwd_sel=0, pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, exmem_flush=0, hazard_stall=0.
- Reset mid-stall abandons the stall immediately, with no residual bubble.

## Configuration
- HAZ_FWD_EN defined: forwarding behaves as described above.
- HAZ_FWD_EN undefined:
  - fwd_sel is held at 0.
  - Any hit on the EX or MEM entry (load or not) stalls with the load-use response.
  - The stall repeats until no hit remains, so a dependent pair costs 2 stall cycles.
  - Redirect and ext_stall rules are unchanged.

## Structure
- Shared package haz_pkg holds FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2 and the scoreboard-entry struct typedef.
- One sub-module, haz_src_match: one source against both scoreboard entries, producing hit_ex, hit_mem and load_hit. It is instantiated NUM_SRC times.

## Test plan
- ADD R1,R2,R3 followed by ADD R4,R1,R5 -> no stall; fwd_sel[src0]=1 during the second instruction's EX cycle.
- LDD R2 followed by ADD R3,R2,R2:
  - exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1;
  - then fwd_sel=2 for both sources.
- ex_redirect pulse for one cycle -> ifid_flush=1 and idex_bubble=1 for that cycle only; the next EX has fwd_sel=0 and the MEM entry is invalid after the bubble moves through.
- mem_redirect asserted in the same cycle as a load-use hit -> all three flushes 1, pc_en=1, hazard_stall=0, no stall cycle.
- ext_stall=1 for 3 cycles during a load-use cycle:
  - outputs frozen and the scoreboard unchanged;
  - after release, exactly one stall cycle occurs;
  - rst asserted mid-stall returns all outputs to their reset values.
- HAZ_FWD_EN undefined, back-to-back RAW on R6 -> 2 stall cycles, fwd_sel remains 0 throughout.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select codes
// and the scoreboard entry tracked for the EX and MEM stages.
package haz_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Destination field is sized for the widest register address in use;
    // narrower addresses are zero-extended into it.
    localparam int DST_W = 8;

    typedef struct packed {
        logic             valid;
        logic             reg_wr;
        logic             mem_rd;
        logic [DST_W-1:0] dst;
    } sb_entry_t;

endpackage

// File: rtl/haz_src_match.sv
// Compares one ID source operand against the EX and MEM scoreboard entries.
module haz_src_match
    import haz_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic [AW-1:0] src_addr,
    input  logic          src_used,
    input  sb_entry_t     ex_entry,
    input  sb_entry_t     mem_entry,
    output logic          hit_ex,
    output logic          hit_mem,
    output logic          load_hit
);

    logic [DST_W-1:0] src_ext;
    logic             unused_mem_rd;

    assign src_ext = DST_W'(src_addr);

    assign hit_ex   = src_used & ex_entry.valid  & ex_entry.reg_wr  & (ex_entry.dst  == src_ext);
    assign hit_mem  = src_used & mem_entry.valid & mem_entry.reg_wr & (mem_entry.dst == src_ext);
    // Only a load still in EX is too late to forward; one in MEM forwards from MEM/WB.
    assign load_hit = hit_ex & ex_entry.mem_rd;

    assign unused_mem_rd = mem_entry.mem_rd;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection, forwarding selects and stage-register control for the
// 5-stage core. Define HAZ_FWD_EN to enable operand forwarding.
module pipe_hazard_unit
    import haz_pkg::*;
#(
    parameter int AW      = 3,
    parameter int NUM_SRC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic [AW-1:0]          id_dst_addr,
    input  logic                   id_reg_wr,
    input  logic                   id_mem_rd,
    input  logic                   ex_redirect,
    input  logic                   mem_redirect,
    input  logic                   ext_stall,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   exmem_flush,
    output logic [NUM_SRC*2-1:0]   fwd_sel,
    output logic                   hazard_stall
);

    sb_entry_t          ex_q;
    sb_entry_t          mem_q;
    sb_entry_t          id_entry;
    logic [NUM_SRC-1:0] hit_ex;
    logic [NUM_SRC-1:0] hit_mem;
    logic [NUM_SRC-1:0] load_hit;
    logic               raw_stall;
    logic               advance;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        haz_src_match #(.AW(AW)) u_match (
            .src_addr  (id_src_addr[i*AW +: AW]),
            .src_used  (id_src_used[i]),
            .ex_entry  (ex_q),
            .mem_entry (mem_q),
            .hit_ex    (hit_ex[i]),
            .hit_mem   (hit_mem[i]),
            .load_hit  (load_hit[i])
        );
    end

`ifdef HAZ_FWD_EN
    assign raw_stall = id_valid & (|load_hit);
`else
    // Without forwarding every in-flight producer must reach WB first.
    logic unused_load_hit;
    assign unused_load_hit = ^load_hit;
    assign raw_stall = id_valid & (|(hit_ex | hit_mem));
`endif

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_flush  = 1'b0;
        hazard_stall = 1'b0;
        if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (mem_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (raw_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_bubble  = 1'b1;
            hazard_stall = 1'b1;
        end
    end

    // The bubble output already covers stalls and both redirect kinds.
    assign advance = id_valid & ~idex_bubble;

    always_comb begin
        id_entry.valid  = 1'b1;
        id_entry.reg_wr = id_reg_wr;
        id_entry.mem_rd = id_mem_rd;
        id_entry.dst    = DST_W'(id_dst_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!ext_stall) begin
            ex_q  <= advance ? id_entry : '0;
            mem_q <= exmem_flush ? '0 : ex_q;
        end
    end

`ifdef HAZ_FWD_EN
    logic [NUM_SRC*2-1:0] fwd_next;

    always_comb begin
        fwd_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (advance && hit_ex[i]) begin
                fwd_next[i*2 +: 2] = FWD_EXMEM;
            end else if (advance && hit_mem[i]) begin
                fwd_next[i*2 +: 2] = FWD_MEMWB;
            end else begin
                fwd_next[i*2 +: 2] = FWD_RF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel <= '0;
        end else if (!ext_stall) begin
            fwd_sel <= fwd_next;
        end
    end
`else
    assign fwd_sel = '0;
`endif

endmodule
